kyber_keygen_seq: RTL

- Parametrised, sequential Baby-Kyber key generator.
- Samples the matrix A, the secret s and the error e from a seeded LFSR, then computes t = A·s + e in the negacyclic ring Z_Q[x]/(x^N+1) using one shared multiply-accumulate unit.
- Streams t and s out over a valid/ready interface.
- Sits ahead of the encryption/decryption blocks and replaces the fixed 2×4, all-parallel key generator.

---
 rtl/kyber_pkg.sv | 49 ++++
 rtl/kyber_sampler.sv | 50 +++++
 rtl/kyber_keygen_seq.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kyber_pkg.sv
// Shared types, FSM encoding and modular arithmetic helpers for the Baby-Kyber key generator.
// Helpers work on the widest supported coefficient (Q up to 4095) and take the modulus as an argument.
package kyber_pkg;

  localparam int CW = 12;
  typedef logic [CW-1:0] coeff_t;

  typedef enum logic [1:0] {
    TAG_T = 2'd0,
    TAG_S = 2'd1,
    TAG_A = 2'd2
  } tag_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE_A,
    ST_SAMPLE_S,
    ST_SAMPLE_E,
    ST_MULT,
    ST_ADD_E,
    ST_STREAM
  } kg_state_e;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  function automatic coeff_t mod_add(input coeff_t a, input coeff_t b, input coeff_t q);
    logic [CW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= {1'b0, q}) sum = sum - {1'b0, q};
    return sum[CW-1:0];
  endfunction

  function automatic coeff_t mod_sub(input coeff_t a, input coeff_t b, input coeff_t q);
    logic [CW:0] dif;
    if (a >= b) dif = {1'b0, a} - {1'b0, b};
    else        dif = {1'b0, a} + {1'b0, q} - {1'b0, b};
    return dif[CW-1:0];
  endfunction

  function automatic coeff_t mod_mul_acc(input coeff_t acc, input coeff_t a, input coeff_t b,
                                         input logic neg, input coeff_t q);
    logic [2*CW-1:0] prod;
    coeff_t          red;
    prod = {{CW{1'b0}}, a} * {{CW{1'b0}}, b};
    red  = coeff_t'(prod % {{CW{1'b0}}, q});
    return neg ? mod_sub(acc, red, q) : mod_add(acc, red, q);
  endfunction

endpackage

// File: rtl/kyber_sampler.sv
// Seeded 32-bit Galois LFSR feeding uniform rejection sampling (A) and centred binomial sampling (s, e).
// mode = 0 selects uniform, mode = 1 selects CBD; the LFSR advances only while en is high.
module kyber_sampler
  import kyber_pkg::*;
#(
  parameter int Q   = 17,
  parameter int ETA = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 mode,
  input  logic                 seed_load,
  input  logic [31:0]          seed,
  output logic [$clog2(Q)-1:0] coeff,
  output logic                 accept
);

  localparam int CQ = $clog2(Q);

  logic [31:0]   lfsr_q, lfsr_d;
  logic [CQ-1:0] uni, cbd;
  int            pa, pb;

  always_comb begin
    lfsr_d = lfsr_q;
    if (seed_load)  lfsr_d = (seed == 32'h0) ? 32'h1 : seed;
    else if (en)    lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
  end

  // The current LFSR value is consumed this cycle; the stepped value serves the next one.
  always_comb begin
    pa = 0;
    pb = 0;
    for (int i = 0; i < ETA; i++) begin
      pa = pa + int'(lfsr_q[i]);
      pb = pb + int'(lfsr_q[ETA+i]);
    end
    uni    = lfsr_q[CQ-1:0];
    cbd    = CQ'((pa - pb + 2 * Q) % Q);
    coeff  = mode ? cbd : uni;
    accept = en & (mode | (uni < CQ'(Q)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= '0;
    else        lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/kyber_keygen_seq.sv
// Sequential Baby-Kyber key generator: samples A, s, e, computes t = A*s + e in Z_Q[x]/(x^N+1), streams t then s.
// Defining KYBER_KEYGEN_STREAM_A_EN appends the K*K*N coefficients of A to the output stream.
module kyber_keygen_seq
  import kyber_pkg::*;
#(
  parameter int K   = 2,
  parameter int N   = 4,
  parameter int Q   = 17,
  parameter int ETA = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [31:0]             seed,
  output logic                    busy,
  output logic                    done,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              out_tag,
  output logic [$clog2(K*K)-1:0]  out_poly,
  output logic [$clog2(N)-1:0]    out_idx,
  output logic [$clog2(Q)-1:0]    out_coeff
);

  localparam int CQ  = $clog2(Q);
  localparam int PW  = $clog2(K*K);
  localparam int IW  = $clog2(N);
  localparam int KN  = K * N;
  localparam int KKN = K * K * N;
  localparam int SAW = $clog2(KN);
  localparam int AAW = $clog2(KKN);
`ifdef KYBER_KEYGEN_STREAM_A_EN
  localparam int BEATS = 2 * KN + KKN;
`else
  localparam int BEATS = 2 * KN;
`endif
  localparam int CNTW = $clog2(BEATS + KKN + 1);

  localparam logic [CNTW-1:0] KN_C     = CNTW'(KN);
  localparam logic [CNTW-1:0] KN2_C    = CNTW'(2 * KN);
  localparam logic [CNTW-1:0] KN_M1    = CNTW'(KN - 1);
  localparam logic [CNTW-1:0] KKN_M1   = CNTW'(KKN - 1);
  localparam logic [CNTW-1:0] BEATS_M1 = CNTW'(BEATS - 1);
  localparam logic [SAW-1:0]  KN_LAST  = SAW'(KN - 1);
  localparam coeff_t          Q_C      = coeff_t'(Q);

  kg_state_e       state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [SAW-1:0]  rk_q, rk_d, ci_q, ci_d;
  logic [CQ-1:0]   acc_q, acc_d;

  logic [CQ-1:0] a_q [2**AAW];
  logic [CQ-1:0] a_d [2**AAW];
  logic [CQ-1:0] s_q [2**SAW];
  logic [CQ-1:0] s_d [2**SAW];
  logic [CQ-1:0] e_q [2**SAW];
  logic [CQ-1:0] e_d [2**SAW];
  logic [CQ-1:0] t_q [2**SAW];
  logic [CQ-1:0] t_d [2**SAW];

  logic          busy_q, busy_d, done_q, done_d, out_valid_q, out_valid_d;
  logic [1:0]    out_tag_q, out_tag_d;
  logic [PW-1:0] out_poly_q, out_poly_d;
  logic [IW-1:0] out_idx_q, out_idx_d;
  logic [CQ-1:0] out_coeff_q, out_coeff_d;

  logic          samp_en, samp_mode, samp_load, samp_accept;
  logic [CQ-1:0] samp_coeff;

  assign samp_en   = (state_q == ST_SAMPLE_A) || (state_q == ST_SAMPLE_S) || (state_q == ST_SAMPLE_E);
  assign samp_mode = (state_q != ST_SAMPLE_A);
  assign samp_load = (state_q == ST_IDLE) && start;

  kyber_sampler #(.Q(Q), .ETA(ETA)) u_sampler (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (samp_en),
    .mode      (samp_mode),
    .seed_load (samp_load),
    .seed      (seed),
    .coeff     (samp_coeff),
    .accept    (samp_accept)
  );

  // MAC operand selection: output coefficient (r,k), partial product index (c,i), j = (k-i) mod N.
  logic [SAW-1:0] m_r, m_c;
  logic [IW-1:0]  m_k, m_i, m_j;
  logic           m_neg;
  logic [AAW-1:0] m_aidx;
  logic [SAW-1:0] m_sidx;
  logic [CQ-1:0]  m_base, mac_res;

  always_comb begin
    m_r     = rk_q >> IW;
    m_k     = rk_q[IW-1:0];
    m_c     = ci_q >> IW;
    m_i     = ci_q[IW-1:0];
    m_j     = m_k - m_i;
    m_neg   = (m_i > m_k);
    m_aidx  = AAW'((int'(m_r) * K + int'(m_c)) * N + int'(m_i));
    m_sidx  = SAW'(int'(m_c) * N + int'(m_j));
    m_base  = (ci_q == '0) ? '0 : acc_q;
    mac_res = CQ'(mod_mul_acc(coeff_t'(m_base), coeff_t'(a_q[m_aidx]), coeff_t'(s_q[m_sidx]),
                              m_neg, Q_C));
  end

  // Stream fetch: fields of the beat presented after the current one.
  logic [CNTW-1:0] nb, f_off;
  logic [1:0]      f_tag;
  logic [PW-1:0]   f_poly;
  logic [IW-1:0]   f_idx;
  logic [CQ-1:0]   f_coeff;

  always_comb begin
    nb      = (state_q == ST_STREAM) ? cnt_q + CNTW'(1) : '0;
    f_off   = '0;
    f_tag   = '0;
    f_poly  = '0;
    f_idx   = '0;
    f_coeff = '0;
    if (nb < KN_C) begin
      f_tag   = TAG_T;
      f_poly  = PW'(nb >> IW);
      f_idx   = nb[IW-1:0];
      f_coeff = t_q[nb[SAW-1:0]];
    end else if (nb < KN2_C) begin
      f_off   = nb - KN_C;
      f_tag   = TAG_S;
      f_poly  = PW'(f_off >> IW);
      f_idx   = f_off[IW-1:0];
      f_coeff = s_q[f_off[SAW-1:0]];
    end
`ifdef KYBER_KEYGEN_STREAM_A_EN
    else begin
      f_off   = nb - KN2_C;
      f_tag   = TAG_A;
      f_poly  = PW'(f_off >> IW);
      f_idx   = f_off[IW-1:0];
      f_coeff = a_q[f_off[AAW-1:0]];
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rk_d        = rk_q;
    ci_d        = ci_q;
    acc_d       = acc_q;
    a_d         = a_q;
    s_d         = s_q;
    e_d         = e_q;
    t_d         = t_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    out_valid_d = out_valid_q;
    out_tag_d   = out_tag_q;
    out_poly_d  = out_poly_q;
    out_idx_d   = out_idx_q;
    out_coeff_d = out_coeff_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SAMPLE_A;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_SAMPLE_A: begin
        if (samp_accept) begin
          a_d[cnt_q[AAW-1:0]] = samp_coeff;
          if (cnt_q == KKN_M1) begin
            cnt_d   = '0;
            state_d = ST_SAMPLE_S;
          end else cnt_d = cnt_q + CNTW'(1);
        end
      end
      ST_SAMPLE_S: begin
        s_d[cnt_q[SAW-1:0]] = samp_coeff;
        if (cnt_q == KN_M1) begin
          cnt_d   = '0;
          state_d = ST_SAMPLE_E;
        end else cnt_d = cnt_q + CNTW'(1);
      end
      ST_SAMPLE_E: begin
        e_d[cnt_q[SAW-1:0]] = samp_coeff;
        if (cnt_q == KN_M1) begin
          cnt_d   = '0;
          rk_d    = '0;
          ci_d    = '0;
          state_d = ST_MULT;
        end else cnt_d = cnt_q + CNTW'(1);
      end
      ST_MULT: begin
        acc_d = mac_res;
        if (ci_q == KN_LAST) begin
          t_d[rk_q] = mac_res;
          ci_d      = '0;
          if (rk_q == KN_LAST) begin
            rk_d    = '0;
            cnt_d   = '0;
            state_d = ST_ADD_E;
          end else rk_d = rk_q + SAW'(1);
        end else ci_d = ci_q + SAW'(1);
      end
      ST_ADD_E: begin
        t_d[cnt_q[SAW-1:0]] = CQ'(mod_add(coeff_t'(t_q[cnt_q[SAW-1:0]]),
                                          coeff_t'(e_q[cnt_q[SAW-1:0]]), Q_C));
        if (cnt_q == KN_M1) begin
          cnt_d       = '0;
          state_d     = ST_STREAM;
          out_valid_d = 1'b1;
          out_tag_d   = f_tag;
          out_poly_d  = f_poly;
          out_idx_d   = f_idx;
          out_coeff_d = f_coeff;
        end else cnt_d = cnt_q + CNTW'(1);
      end
      ST_STREAM: begin
        if (out_valid_q && out_ready) begin
          if (cnt_q == BEATS_M1) begin
            cnt_d       = '0;
            state_d     = ST_IDLE;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            out_valid_d = 1'b0;
            out_tag_d   = '0;
            out_poly_d  = '0;
            out_idx_d   = '0;
            out_coeff_d = '0;
          end else begin
            cnt_d       = cnt_q + CNTW'(1);
            out_tag_d   = f_tag;
            out_poly_d  = f_poly;
            out_idx_d   = f_idx;
            out_coeff_d = f_coeff;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rk_q        <= '0;
      ci_q        <= '0;
      acc_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_poly_q  <= '0;
      out_idx_q   <= '0;
      out_coeff_q <= '0;
      for (int n = 0; n < 2**AAW; n++) a_q[n] <= '0;
      for (int n = 0; n < 2**SAW; n++) begin
        s_q[n] <= '0;
        e_q[n] <= '0;
        t_q[n] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rk_q        <= rk_d;
      ci_q        <= ci_d;
      acc_q       <= acc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_tag_q   <= out_tag_d;
      out_poly_q  <= out_poly_d;
      out_idx_q   <= out_idx_d;
      out_coeff_q <= out_coeff_d;
      a_q         <= a_d;
      s_q         <= s_d;
      e_q         <= e_d;
      t_q         <= t_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_tag   = out_tag_q;
  assign out_poly  = out_poly_q;
  assign out_idx   = out_idx_q;
  assign out_coeff = out_coeff_q;

endmodule
